lsu_arbiter: RTL
================

// Module: lsu_arbiter
// PURPOSE
//  Shares the single LSU port (data memory, switch input buffer, LED/HEX/LCD output buffer)
//  between two requesters: M0 = core load/store path, M1 = debug/boot loader.
//  Fixed priority to M0 with a starvation guard, plus an M1 bus lock for atomic bursts.
//  Forwards the granted request to the LSU in the same cycle.
//  Returns registered load data one cycle later. Sits between the core/loader and lsu.
// PARAMETERS
//  STARVE_MAX  4  consecutive M0 grants tolerated while M1 waits; then M1 is forced through
//  LOCK_MAX    16 max cycles M1 may hold the lock before it is forcibly released
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset        in   1   asynchronous, active-high reset
//  i_m0_req       in   1   M0 request valid
//  i_m0_addr      in   32  M0 address
//  i_m0_wdata     in   32  M0 store data
//  i_m0_wren      in   1   M0 store (1) / load (0)
//  i_m0_bmask     in   4   M0 byte mask
//  i_m0_u         in   1   M0 unsigned load
//  o_m0_gnt       out  1   M0 request accepted this cycle (combinational)
//  o_m0_rvalid    out  1   M0 load data valid (1 cycle after the load grant)
//  o_m0_rdata     out  32  M0 registered load data
//  i_m1_req / i_m1_addr / i_m1_wdata / i_m1_wren / i_m1_bmask / i_m1_u   in   as M0
//  i_m1_lock      in   1   M1 requests exclusive ownership
//  o_m1_gnt / o_m1_rvalid / o_m1_rdata                                   out  as M0
//  o_lsu_addr     out  32  to lsu i_lsu_addr
//  o_lsu_st_data  out  32  to lsu i_st_data
//  o_lsu_wren     out  1   to lsu i_lsu_wren
//  o_lsu_bmask    out  4   to lsu i_bmask
//  o_lsu_u        out  1   to lsu i_u
//  i_lsu_ld_data  in   32  from lsu o_ld_data (combinational read)
// BEHAVIOUR
//  - Reset: state=IDLE, starve_cnt=0, lock_cnt=0, rvalid=0, rdata=0.
//    A pending rvalid is dropped on reset; gnt is 0 while i_reset is high.
//  - At most one gnt per cycle. A request is accepted when req && gnt.
//    The requester holds its fields until granted.
//  - IDLE arbitration:
//    - M1 wins if i_m1_req && (!i_m0_req || starve_cnt==STARVE_MAX).
//    - Otherwise M0 wins if i_m0_req.
//    - Otherwise no grant.
//  - starve_cnt: +1 (saturating at STARVE_MAX) when M0 is granted while i_m1_req;
//    cleared when M1 is granted or when !i_m1_req.
//  - LSU mux: winner's fields drive o_lsu_*. With no grant, o_lsu_* carry M0's fields
//    but o_lsu_wren=0.
//  - Store: the LSU commits at the rising edge ending the grant cycle. No rvalid is produced.
//  - Load: i_lsu_ld_data is sampled at the edge ending the grant cycle into mX_rdata.
//    mX_rvalid=1 for exactly the next cycle; rdata holds its value until the next load.
//    Back-to-back loads give one rvalid per cycle.
//  - FSM states: IDLE, M1_LOCK.
//    - IDLE->M1_LOCK: M1 granted with i_m1_lock=1; lock_cnt=1.
//    - In M1_LOCK: o_m0_gnt=0; o_m1_gnt=i_m1_req; lock_cnt increments every cycle.
//    - M1_LOCK->IDLE: at the edge where i_m1_lock=0, or lock_cnt==LOCK_MAX
//      (forced release, starve_cnt cleared).
//    - A grant already issued in the exit cycle completes normally.
//  - Simultaneous M0 and M1 requests with starve_cnt<STARVE_MAX: M0 granted, M1 waits.
//  - Unmapped addresses are passed through unchanged; the LSU returns 0xDEADBEEF.
//    The arbiter does no address decoding.
// STRUCTURE
//  - lsu_arb_pkg: typedef enum {IDLE, M1_LOCK} arb_state_e; typedef enum {M0, M1} master_e;
//    lsu_req_t struct {addr, wdata, wren, bmask, u}.
//  - Sub-module lsu_arb_prio: combinational winner select from
//    (req0, req1, starve_hit, locked) -> gnt0, gnt1.
//  - Top holds the FSM, counters, request mux and rdata/rvalid registers.
// TESTING
//  1. Reset: assert i_reset mid-load.
//     -> rvalid=0, rdata=0 immediately; the next cycle after release has no gnt without req.
//  2. M0 alone: load addr 0x0000_0010 holding 0x1234_5678.
//     -> o_m0_gnt same cycle; o_m0_rvalid=1 with rdata=0x1234_5678 next cycle only.
//  3. Contention: M0 and M1 request continuously, STARVE_MAX=4.
//     -> grant pattern M0,M0,M0,M0,M1 repeating.
//  4. Lock: M1 stores 0xA5 to 0x1000_0000 with lock=1 for 3 cycles while M0 requests.
//     -> M0 gnt=0 throughout; ledr=0xA5; M0 granted the cycle after lock drops.
//  5. Lock timeout: M1 holds lock 20 cycles, LOCK_MAX=16.
//     -> forced IDLE after 16 cycles; M0 granted in the next cycle.
//  6. Switch read: M1 loads 0x1001_0000 with i_io_sw=0x0000_03FF.
//     -> o_m1_rvalid with rdata=0x0000_03FF; o_m0_rvalid stays 0.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types for the LSU port arbiter: FSM states, master ids and the request payload.
package lsu_arb_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BMASK_W = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        M1_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic               wren;
        logic [BMASK_W-1:0] bmask;
        logic               u;
    } lsu_req_t;

endpackage

// File: rtl/lsu_arb_prio.sv
// Combinational winner select: M0 has priority unless M1 is starved or holds the lock.
module lsu_arb_prio (
    input  logic req0,
    input  logic req1,
    input  logic starve_hit,
    input  logic locked,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (locked) begin
            gnt1 = req1;
        end else if (req1 && (!req0 || starve_hit)) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = req0;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares one LSU port between the core (M0) and the debug/boot loader (M1), with
// a starvation guard for M1, an M1 bus lock for atomic bursts and registered load return.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic        i_m0_wren,
    input  logic [3:0]  i_m0_bmask,
    input  logic        i_m0_u,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic        i_m1_wren,
    input  logic [3:0]  i_m1_bmask,
    input  logic        i_m1_u,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_st_data,
    output logic        o_lsu_wren,
    output logic [3:0]  o_lsu_bmask,
    output logic        o_lsu_u,
    input  logic [31:0] i_lsu_ld_data
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int unsigned LOCK_W   = $clog2(LOCK_MAX + 1);

    arb_state_e          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [LOCK_W-1:0]   lock_cnt;

    logic     req0_v;
    logic     req1_v;
    logic     starve_hit;
    logic     locked;
    logic     lock_timeout;
    logic     lock_exit;
    logic     m0_load;
    logic     m1_load;
    master_e  winner;
    lsu_req_t m0_bus;
    lsu_req_t m1_bus;
    lsu_req_t sel_bus;

    // No grants may escape while reset is held.
    assign req0_v = i_m0_req && !i_reset;
    assign req1_v = i_m1_req && !i_reset;

    assign starve_hit   = (starve_cnt == STARVE_W'(STARVE_MAX));
    assign locked       = (state == M1_LOCK);
    assign lock_timeout = locked && (lock_cnt == LOCK_W'(LOCK_MAX));
    assign lock_exit    = locked && (!i_m1_lock || lock_timeout);

    lsu_arb_prio u_prio (
        .req0       (req0_v),
        .req1       (req1_v),
        .starve_hit (starve_hit),
        .locked     (locked),
        .gnt0       (o_m0_gnt),
        .gnt1       (o_m1_gnt)
    );

    assign m0_bus = '{addr: i_m0_addr, wdata: i_m0_wdata, wren: i_m0_wren,
                      bmask: i_m0_bmask, u: i_m0_u};
    assign m1_bus = '{addr: i_m1_addr, wdata: i_m1_wdata, wren: i_m1_wren,
                      bmask: i_m1_bmask, u: i_m1_u};

    // With no grant the port idles on M0's fields, but never writes.
    assign winner  = o_m1_gnt ? M1 : M0;
    assign sel_bus = (winner == M1) ? m1_bus : m0_bus;

    assign o_lsu_addr    = sel_bus.addr;
    assign o_lsu_st_data = sel_bus.wdata;
    assign o_lsu_wren    = sel_bus.wren && (o_m0_gnt || o_m1_gnt);
    assign o_lsu_bmask   = sel_bus.bmask;
    assign o_lsu_u       = sel_bus.u;

    assign m0_load = o_m0_gnt && !i_m0_wren;
    assign m1_load = o_m1_gnt && !i_m1_wren;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            lock_cnt    <= '0;
            o_m0_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rvalid <= 1'b0;
            o_m1_rdata  <= '0;
        end else begin
            if (state == IDLE) begin
                if (o_m1_gnt && i_m1_lock) begin
                    state    <= M1_LOCK;
                    lock_cnt <= LOCK_W'(1);
                end
            end else if (lock_exit) begin
                state    <= IDLE;
                lock_cnt <= '0;
            end else begin
                lock_cnt <= lock_cnt + LOCK_W'(1);
            end

            // Count M0 wins while M1 waits; any M1 win or M1 withdrawal resets it.
            if (o_m1_gnt || !req1_v || lock_timeout) begin
                starve_cnt <= '0;
            end else if (o_m0_gnt && !starve_hit) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end

            o_m0_rvalid <= m0_load;
            o_m1_rvalid <= m1_load;
            if (m0_load) begin
                o_m0_rdata <= i_lsu_ld_data;
            end
            if (m1_load) begin
                o_m1_rdata <= i_lsu_ld_data;
            end
        end
    end

endmodule
